// File: rtl/debounce.sv
// debounce: 2-FF synchroniser plus stability counter/FSM; out follows in only after STABLE_CYCLES clean cycles.
// Optional DEBOUNCE_EDGE_EN adds registered rise/fall pulses on out transitions.
module debounce #(
  parameter int   STABLE_CYCLES = 500000,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic busy
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);
  localparam int CNT_WIDTH = $clog2(STABLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);
  typedef enum logic {STABLE, WAIT} state_t;
  state_t state_q, state_d;
  logic s1_q, s1_d, s2_q, s2_d, out_q, out_d, busy_q, busy_d, diff, done;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    s1_d = in;
    s2_d = s1_q;
    diff = s2_q != out_q;
    done = state_q == WAIT && diff && cnt_q == CNT_MAX;
    state_d = (state_q == STABLE) ? (diff ? WAIT : STABLE) : ((diff && !done) ? WAIT : STABLE);
    cnt_d = (state_q == WAIT && diff && !done) ? cnt_q + 1'b1 : '0;
    out_d = done ? s2_q : out_q;
    busy_d = state_d == WAIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RESET_LEVEL;
      s2_q <= RESET_LEVEL;
      out_q <= RESET_LEVEL;
      state_q <= STABLE;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      out_q <= out_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
  assign out = out_q;
  assign busy = busy_q;
`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end
  assign rise = rise_q;
  assign fall = fall_q;
`endif
endmodule

// File: tb/tb_debounce.sv
// tb_debounce: directed checks of debounce with STABLE_CYCLES=4, RESET_LEVEL 0 (dut0) and 1 (dut1).
module tb_debounce;
  logic clk = 1'b0, rst = 1'b1, in0 = 1'b1, in1 = 1'b1;
  logic out0, busy0, out1, busy1;
  logic rise0, fall0, rise1, fall1;
  int checks = 0, errors = 0;
  logic out_seen, rise_seen, busy_seen;
  always #5 clk = ~clk;
`ifdef DEBOUNCE_EDGE_EN
  debounce #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b0)) dut0 (.clk(clk), .rst(rst), .in(in0), .out(out0), .busy(busy0), .rise(rise0), .fall(fall0));
  debounce #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b1)) dut1 (.clk(clk), .rst(rst), .in(in1), .out(out1), .busy(busy1), .rise(rise1), .fall(fall1));
`else
  debounce #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b0)) dut0 (.clk(clk), .rst(rst), .in(in0), .out(out0), .busy(busy0));
  debounce #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b1)) dut1 (.clk(clk), .rst(rst), .in(in1), .out(out1), .busy(busy1));
  assign rise0 = 1'b0;
  assign fall0 = 1'b0;
  assign rise1 = 1'b0;
  assign fall1 = 1'b0;
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic edges(input string tag, input logic r0, input logic f0, input logic r1, input logic f1);
`ifdef DEBOUNCE_EDGE_EN
    chk({tag, "_rise0"}, rise0, r0);
    chk({tag, "_fall0"}, fall0, f0);
    chk({tag, "_rise1"}, rise1, r1);
    chk({tag, "_fall1"}, fall1, f1);
`endif
  endtask
  initial begin
    // reset with in held high
    step(2);
    chk("rst_out0", out0, 1'b0);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_out1", out1, 1'b1);
    chk("rst_busy1", busy1, 1'b0);
    edges("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(6);
    chk("t1_out_e6", out0, 1'b0);
    chk("t1_busy_e6", busy0, 1'b1);
    step(1);
    chk("t1_out_e7", out0, 1'b1);
    chk("t1_busy_e7", busy0, 1'b0);
    edges("t1_e7", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    edges("t1_e8", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_out1_stable", out1, 1'b1);
    // 1->0 then 0->1 with busy window edges 3..6
    in0 = 1'b0;
    step(2);
    chk("t2_busy_e2", busy0, 1'b0);
    step(1);
    chk("t2_busy_e3", busy0, 1'b1);
    step(3);
    chk("t2_busy_e6", busy0, 1'b1);
    chk("t2_out_e6", out0, 1'b1);
    step(1);
    chk("t2_out_e7", out0, 1'b0);
    chk("t2_busy_e7", busy0, 1'b0);
    edges("t2_fall", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    edges("t2_fall_end", 1'b0, 1'b0, 1'b0, 1'b0);
    in0 = 1'b1;
    step(6);
    chk("t2_rise_out_e6", out0, 1'b0);
    step(1);
    chk("t2_rise_out_e7", out0, 1'b1);
    edges("t2_rise", 1'b1, 1'b0, 1'b0, 1'b0);
    in0 = 1'b0;
    step(8);
    chk("t2_back_low", out0, 1'b0);
    // toggling every 2 cycles never survives the stability window
    out_seen = 1'b0;
    rise_seen = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in0 = (i < 20) ? ((i / 2) % 2 == 0) : 1'b0;
      step(1);
      out_seen |= out0;
      rise_seen |= rise0;
      busy_seen |= busy0;
    end
    chk("t3_out_never", out_seen, 1'b0);
    chk("t3_rise_never", rise_seen, 1'b0);
    chk("t3_busy_pulsed", busy_seen, 1'b1);
    chk("t3_busy_end", busy0, 1'b0);
    // one-cycle dropout mid-WAIT restarts timing from the final 0->1
    in0 = 1'b1;
    step(4);
    in0 = 1'b0;
    step(1);
    in0 = 1'b1;
    step(2);
    chk("t4_out_abort", out0, 1'b0);
    chk("t4_busy_abort", busy0, 1'b0);
    step(4);
    chk("t4_out_e6", out0, 1'b0);
    step(1);
    chk("t4_out_e7", out0, 1'b1);
    in0 = 1'b0;
    step(8);
    chk("t4_back_low", out0, 1'b0);
    // reset while WAIT is counting
    in0 = 1'b1;
    step(4);
    chk("t5_busy_pre", busy0, 1'b1);
    rst = 1'b1;
    step(1);
    chk("t5_out_rst", out0, 1'b0);
    chk("t5_busy_rst", busy0, 1'b0);
    chk("t5_cnt_rst", dut0.cnt_q, 32'd0);
    edges("t5_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(6);
    chk("t5_out_e6", out0, 1'b0);
    step(1);
    chk("t5_out_e7", out0, 1'b1);
    edges("t5_rise", 1'b1, 1'b0, 1'b0, 1'b0);
    // RESET_LEVEL=1 instance falls after 7 edges
    chk("t6_out1_hi", out1, 1'b1);
    in1 = 1'b0;
    step(6);
    chk("t6_out1_e6", out1, 1'b1);
    chk("t6_busy1_e6", busy1, 1'b1);
    step(1);
    chk("t6_out1_e7", out1, 1'b0);
    edges("t6_fall", 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    edges("t6_fall_end", 1'b0, 1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
